// File: rtl/cp0_exc_unit_pkg.sv
// Shared CP0 definitions: register addresses, exception codes, packed
// SR/Cause layouts and helpers that build the architectural read words.
package cp0_exc_unit_pkg;

  localparam int HWINT_W = 6;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Only the implemented bits are stored; everything else reads as zero.
  typedef struct packed {
    logic [HWINT_W-1:0] im;
    logic               exl;
    logic               ie;
  } sr_t;

  typedef struct packed {
    logic               bd;
    logic [HWINT_W-1:0] ip;
    logic [4:0]         exc_code;
  } cause_t;

  function automatic logic [31:0] sr_word(sr_t s);
    return {16'h0, s.im, 8'h0, s.exl, s.ie};
  endfunction

  function automatic logic [31:0] cause_word(cause_t c);
    return {c.bd, 15'h0, c.ip, 3'h0, c.exc_code, 2'b00};
  endfunction

  // Return address: word-aligned victim PC, backed up to the branch when
  // the victim is in a delay slot. Wraps modulo 2^32.
  function automatic logic [31:0] epc_of(logic [31:0] vpc, logic bd);
    logic [31:0] pc;
    pc = vpc & ~32'h3;
    return bd ? pc - 32'd4 : pc;
  endfunction

endpackage

// File: rtl/cp0_exc_unit_if.sv
// Pipeline <-> CP0 bus. master = M-stage pipeline side, slave = CP0.
interface cp0_exc_unit_if;
  import cp0_exc_unit_pkg::*;

  logic               en;
  logic [4:0]         cp0_addr;
  logic [31:0]        cp0_wdata;
  logic [31:0]        cp0_rdata;
  logic [31:0]        vpc;
  logic               bd_in;
  logic [4:0]         exc_code;
  logic [HWINT_W-1:0] hw_int;
  logic               exl_clr;
  logic               req;
  logic [31:0]        epc_out;

  modport master (
    output en, cp0_addr, cp0_wdata, vpc, bd_in, exc_code, hw_int, exl_clr,
    input  cp0_rdata, req, epc_out
  );

  modport slave (
    input  en, cp0_addr, cp0_wdata, vpc, bd_in, exc_code, hw_int, exl_clr,
    output cp0_rdata, req, epc_out
  );
endinterface

// File: rtl/cp0_exc_unit_int_arb.sv
// cp0_int_arb: combinational interrupt/exception request and ExcCode select.
// Interrupts take priority over synchronous exceptions; EXL masks both.
module cp0_int_arb
  import cp0_exc_unit_pkg::*;
(
  input  logic [HWINT_W-1:0] hw_int_i,
  input  logic [HWINT_W-1:0] im_i,
  input  logic               exl_i,
  input  logic               ie_i,
  input  logic [4:0]         exc_code_i,
  output logic               int_req_o,
  output logic               exc_req_o,
  output logic [4:0]         code_o
);
  assign int_req_o = !exl_i && ie_i && (|(hw_int_i & im_i));
  assign exc_req_o = !exl_i && (exc_code_i != EXC_INT);
  assign code_o    = int_req_o ? EXC_INT : exc_code_i;
endmodule

// File: rtl/cp0_exc_unit.sv
// cp0_exc_unit: M-stage coprocessor 0. Holds SR/Cause/EPC, raises req to
// redirect fetch to the handler, serves mfc0 reads and mtc0 writes.
// Optional build macro CP0_EPC_FWD_EN: forward an in-flight mtc0 EPC value
// onto epc_out so an eret right behind it needs no stall.
module cp0_exc_unit
  import cp0_exc_unit_pkg::*;
#(
  parameter logic [31:0] PRID_VAL = 32'h2023_0007
) (
  input  logic                 clk,
  input  logic                 reset,
  cp0_exc_unit_if.slave        bus
);
  sr_t         sr_q, sr_d;
  cause_t      cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic        int_req, exc_req, req;
  logic [4:0]  code;
  logic        wr_sr, wr_epc;

  cp0_int_arb u_arb (
    .hw_int_i   (bus.hw_int),
    .im_i       (sr_q.im),
    .exl_i      (sr_q.exl),
    .ie_i       (sr_q.ie),
    .exc_code_i (bus.exc_code),
    .int_req_o  (int_req),
    .exc_req_o  (exc_req),
    .code_o     (code)
  );

  // Held low while reset is asserted so no redirect escapes during reset.
  assign req     = (int_req | exc_req) & reset;
  assign bus.req = req;

  // A request in the same cycle drops the mtc0.
  assign wr_sr  = bus.en && !req && (bus.cp0_addr == CP0_SR);
  assign wr_epc = bus.en && !req && (bus.cp0_addr == CP0_EPC);

  // Next-state: exception entry beats mtc0; exl_clr beats an SR write's EXL.
  always_comb begin
    sr_d       = sr_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    cause_d.ip = bus.hw_int;
    if (req) begin
      sr_d.exl         = 1'b1;
      cause_d.bd       = bus.bd_in;
      cause_d.exc_code = code;
      epc_d            = epc_of(bus.vpc, bus.bd_in);
    end else begin
      if (wr_sr) begin
        sr_d.im  = bus.cp0_wdata[15:10];
        sr_d.exl = bus.cp0_wdata[1];
        sr_d.ie  = bus.cp0_wdata[0];
      end
      if (bus.exl_clr) sr_d.exl = 1'b0;
      if (wr_epc)      epc_d    = bus.cp0_wdata;
    end
  end

  // CP0 register file.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q    <= '0;
      cause_q <= '0;
      epc_q   <= '0;
    end else begin
      sr_q    <= sr_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
    end
  end

  // mfc0 read mux: register contents only, never same-cycle wdata.
  always_comb begin
    bus.cp0_rdata = 32'h0;
    case (bus.cp0_addr)
      CP0_SR:    bus.cp0_rdata = sr_word(sr_q);
      CP0_CAUSE: bus.cp0_rdata = cause_word(cause_q);
      CP0_EPC:   bus.cp0_rdata = epc_q;
      CP0_PRID:  bus.cp0_rdata = PRID_VAL;
      default:   bus.cp0_rdata = 32'h0;
    endcase
  end

`ifdef CP0_EPC_FWD_EN
  assign bus.epc_out = wr_epc ? bus.cp0_wdata : epc_q;
`else
  assign bus.epc_out = epc_q;
`endif

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Scoreboard bench for cp0_exc_unit: each directed step pushes its
// hand-computed expected req/rdata/epc_out; a negedge monitor pops and checks.
module tb_cp0_exc_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;

`ifdef CP0_EPC_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    string       name;
    logic        req;
    logic [31:0] rdata;
    logic [31:0] epc;
  } exp_t;

  exp_t sb[$];

  cp0_exc_unit_if bus();

  cp0_exc_unit #(.PRID_VAL(32'h2023_0007)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Monitor: outputs are combinational, so every cycle with a pending
  // expectation presents a response; compare mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_run++;
      if (bus.req !== e.req) begin
        n_fail++;
        $display("FAIL %s.req got %0b want %0b", e.name, bus.req, e.req);
      end
      n_run++;
      if (bus.cp0_rdata !== e.rdata) begin
        n_fail++;
        $display("FAIL %s.rdata got %08h want %08h", e.name, bus.cp0_rdata, e.rdata);
      end
      n_run++;
      if (bus.epc_out !== e.epc) begin
        n_fail++;
        $display("FAIL %s.epc_out got %08h want %08h", e.name, bus.epc_out, e.epc);
      end
    end
  end

  task automatic step(input string nm, input logic rst, input logic en,
                      input logic [4:0] a, input logic [31:0] wd,
                      input logic [31:0] vpc, input logic bd,
                      input logic [4:0] ec, input logic [5:0] hw,
                      input logic xc, input logic ereq,
                      input logic [31:0] erd, input logic [31:0] eepc);
    exp_t e;
    @(posedge clk);
    #1;
    reset         = rst;
    bus.en        = en;
    bus.cp0_addr  = a;
    bus.cp0_wdata = wd;
    bus.vpc       = vpc;
    bus.bd_in     = bd;
    bus.exc_code  = ec;
    bus.hw_int    = hw;
    bus.exl_clr   = xc;
    e.name = nm; e.req = ereq; e.rdata = erd; e.epc = eepc;
    sb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.en = 0; bus.cp0_addr = 0; bus.cp0_wdata = 0; bus.vpc = 0;
    bus.bd_in = 0; bus.exc_code = 0; bus.hw_int = 0; bus.exl_clr = 0;
    //    name            rst en addr wdata          vpc           bd ec  hw         xc  req rdata          epc_out
    step("rst_hold",      0, 0, 12, 32'h0,         32'h0,         0, 12, 6'h3F,     0,  0, 32'h0,         32'h0);
    step("rst_rel",       1, 0, 12, 32'h0,         32'h0,         0, 0,  6'h00,     0,  0, 32'h0,         32'h0);
    step("sr_wr",         1, 1, 12, 32'h0000_FC01, 32'h0,         0, 0,  6'h00,     0,  0, 32'h0,         32'h0);
    step("int_take",      1, 0, 12, 32'h0,         32'h0000_1000, 0, 0,  6'b000100, 0,  1, 32'h0000_FC01, 32'h0);
    step("cause_ip",      1, 0, 13, 32'h0,         32'h0,         0, 0,  6'h00,     0,  0, 32'h0000_1000, 32'h0000_1000);
    step("exl_block",     1, 0, 12, 32'h0,         32'h0,         0, 10, 6'b000001, 0,  0, 32'h0000_FC03, 32'h0000_1000);
    step("eret1",         1, 0, 14, 32'h0,         32'h0,         0, 10, 6'b000001, 1,  0, 32'h0000_1000, 32'h0000_1000);
    step("int_pend",      1, 0, 12, 32'h0,         32'h0000_2000, 0, 0,  6'b000001, 0,  1, 32'h0000_FC01, 32'h0000_1000);
    step("eret2",         1, 0, 13, 32'h0,         32'h0,         0, 0,  6'h00,     1,  0, 32'h0000_0400, 32'h0000_2000);
    step("exc_bd",        1, 0, 12, 32'h0,         32'h0000_3010, 1, 12, 6'h00,     0,  1, 32'h0000_FC01, 32'h0000_2000);
    step("cause_bd",      1, 0, 13, 32'h0,         32'h0,         0, 0,  6'h00,     0,  0, 32'h8000_0030, 32'h0000_300C);
    step("exl_block2",    1, 0, 14, 32'h0,         32'h0,         0, 10, 6'b000001, 0,  0, 32'h0000_300C, 32'h0000_300C);
    step("mtc0_epc",      1, 1, 14, 32'h0000_3100, 32'h0,         0, 0,  6'h00,     0,  0, 32'h0000_300C,
         FWD ? 32'h0000_3100 : 32'h0000_300C);
    step("eret_epc",      1, 0, 14, 32'h0,         32'h0,         0, 0,  6'h00,     1,  0, 32'h0000_3100, 32'h0000_3100);
    step("sr_set_exl",    1, 1, 12, 32'h0000_FC03, 32'h0,         0, 0,  6'h00,     0,  0, 32'h0000_FC01, 32'h0000_3100);
    step("sr_wr_eret",    1, 1, 12, 32'h0000_F403, 32'h0,         0, 0,  6'h00,     1,  0, 32'h0000_FC03, 32'h0000_3100);
    step("sr_rd",         1, 0, 12, 32'h0,         32'h0,         0, 0,  6'h00,     0,  0, 32'h0000_F401, 32'h0000_3100);
    step("en_drop",       1, 1, 12, 32'h0,         32'h0000_4000, 0, 4,  6'h00,     0,  1, 32'h0000_F401, 32'h0000_3100);
    step("sr_exl",        1, 0, 12, 32'h0,         32'h0,         0, 0,  6'h00,     0,  0, 32'h0000_F403, 32'h0000_4000);
    step("cause_adel",    1, 0, 13, 32'h0,         32'h0,         0, 0,  6'h00,     0,  0, 32'h0000_0010, 32'h0000_4000);
    step("prid",          1, 0, 15, 32'h0,         32'h0,         0, 0,  6'h00,     0,  0, 32'h2023_0007, 32'h0000_4000);
    step("addr7",         1, 0, 7,  32'h0,         32'h0,         0, 0,  6'h00,     0,  0, 32'h0,         32'h0000_4000);
    step("eret3",         1, 0, 12, 32'h0,         32'h0,         0, 0,  6'h00,     1,  0, 32'h0000_F403, 32'h0000_4000);
    step("int_over_exc",  1, 0, 13, 32'h0,         32'h0000_5004, 0, 12, 6'b000100, 0,  1, 32'h0000_0010, 32'h0000_4000);
    step("cause_int",     1, 0, 13, 32'h0,         32'h0,         0, 0,  6'h00,     1,  0, 32'h0000_1000, 32'h0000_5004);
    step("masked",        1, 0, 14, 32'h0,         32'h0,         0, 0,  6'b000010, 0,  0, 32'h0000_5004, 32'h0000_5004);
    step("epc_wrap",      1, 0, 12, 32'h0,         32'h0,         1, 5,  6'h00,     0,  1, 32'h0000_F401, 32'h0000_5004);
    step("wrap_rd",       1, 0, 14, 32'h0,         32'h0,         0, 0,  6'h00,     0,  0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    step("cause_ades",    1, 0, 13, 32'h0,         32'h0,         0, 0,  6'h00,     0,  0, 32'h8000_0014, 32'hFFFF_FFFC);
    step("rst_sr",        0, 0, 12, 32'h0,         32'h0,         0, 12, 6'h3F,     0,  0, 32'h0,         32'h0);
    step("rst_cause",     0, 0, 13, 32'h0,         32'h0,         0, 12, 6'h3F,     0,  0, 32'h0,         32'h0);
    step("rst_epc",       0, 0, 14, 32'h0,         32'h0,         0, 12, 6'h3F,     0,  0, 32'h0,         32'h0);
    step("rst_rel2",      1, 0, 12, 32'h0,         32'h0,         0, 0,  6'h00,     0,  0, 32'h0,         32'h0);
    step("post_rst",      1, 0, 13, 32'h0,         32'h0,         0, 0,  6'h00,     0,  0, 32'h0,         32'h0);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 8 && sb.size() != 0; i++) @(negedge clk);
    #1;
    n_run++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
